// File: rtl/dmem_responder.sv
// Word-organised data SRAM behind valid/ready request and response channels.
// Serves one outstanding access at a time, with programmable wait states and byte strobes.
module dmem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Request channel: a request transfers on a rising edge where req_valid & req_ready.
  // Response channel: a response transfers on a rising edge where resp_valid & resp_ready;
  // resp_rdata/resp_err stay stable while resp_valid is high and resp_ready is low.

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [31:0] mem [0:DEPTH-1];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_err;

  logic          w_err;
  logic [IW-1:0] w_idx;
  logic          w_done;
  logic          w_wr;

  assign w_err  = (r_addr[1:0] != 2'b00) | (r_addr[31:2] >= 30'(DEPTH));
  assign w_idx  = r_addr[IW+1:2];
  assign w_done = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_wr   = w_done & r_we & ~w_err;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_err   <= w_err;
            r_rdata <= (!r_we && !w_err) ? mem[w_idx] : 32'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; a store interrupted by reset never reaches w_wr.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states (u0), one with three (u3).
module tb_dmem_responder;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        req_valid;
  logic        resp_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic [1:0]  a_dbg;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [1:0]  b_dbg;

  wire        cur_ready = sel ? b_req_ready  : a_req_ready;
  wire        cur_valid = sel ? b_resp_valid : a_resp_valid;
  wire        cur_err   = sel ? b_resp_err   : a_resp_err;
  wire [31:0] cur_rdata = sel ? b_resp_rdata : a_resp_rdata;

  int checks;
  int failures;

  dmem_responder #(.DEPTH(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .dbg_state(a_dbg)
  );

  dmem_responder #(.DEPTH(32), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .dbg_state(b_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request and wait (bounded) for resp_valid; lat = edges after the accept edge.
  task automatic send(input bit s, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input bit hold, output int lat, output int rdy_hi);
    @(negedge clk);
    sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    lat = 0;
    rdy_hi = 0;
    forever begin
      if (cur_ready) rdy_hi++;
      if (cur_valid || lat >= 40) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin failures++;
      $display("FAIL reset_req_ready got=%b/%b exp=1/1", a_req_ready, b_req_ready); end
    checks++; if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0) begin failures++;
      $display("FAIL reset_resp_valid got=%b/%b exp=0/0", a_resp_valid, b_resp_valid); end
    checks++; if (a_resp_rdata !== 32'd0 || b_resp_rdata !== 32'd0 || a_resp_err !== 1'b0 || b_resp_err !== 1'b0) begin
      failures++; $display("FAIL reset_resp_data got=%h/%h err=%b/%b exp=0", a_resp_rdata, b_resp_rdata, a_resp_err, b_resp_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_w0();
    int lat, rh;
    u0.mem[0] = 32'hDEADBEEF;
    send(1'b0, 1'b0, 32'd0, 32'd0, 4'hF, 1'b0, lat, rh);
    checks++; if (lat !== 1) begin failures++; $display("FAIL w0_latency got=%0d exp=1", lat); end
    checks++; if (cur_rdata !== 32'hDEADBEEF || cur_err !== 1'b0) begin failures++;
      $display("FAIL w0_load got=%h err=%b exp=deadbeef err=0", cur_rdata, cur_err); end
    checks++; if (rh !== 0) begin failures++; $display("FAIL w0_ready_busy got=%0d exp=0", rh); end
    ack();
    checks++; if (cur_ready !== 1'b1 || cur_valid !== 1'b0 || cur_rdata !== 32'd0) begin failures++;
      $display("FAIL w0_after_ack got ready=%b valid=%b rdata=%h exp 1 0 0", cur_ready, cur_valid, cur_rdata); end
  endtask

  task automatic test_store_strobe();
    int lat, rh;
    send(1'b0, 1'b1, 32'd124, 32'h12345678, 4'hF, 1'b0, lat, rh);
    checks++; if (cur_rdata !== 32'd0 || cur_err !== 1'b0) begin failures++;
      $display("FAIL store_resp got=%h err=%b exp=0 err=0", cur_rdata, cur_err); end
    ack();
    checks++; if (u0.mem[31] !== 32'h12345678) begin failures++;
      $display("FAIL store_full got=%h exp=12345678", u0.mem[31]); end
    send(1'b0, 1'b1, 32'd124, 32'hAABBCCDD, 4'b0011, 1'b0, lat, rh);
    ack();
    checks++; if (u0.mem[31] !== 32'h1234CCDD) begin failures++;
      $display("FAIL store_partial got=%h exp=1234ccdd", u0.mem[31]); end
    send(1'b0, 1'b1, 32'd124, 32'hFFFFFFFF, 4'b0000, 1'b0, lat, rh);
    checks++; if (lat !== 1 || cur_err !== 1'b0) begin failures++;
      $display("FAIL store_nostrobe_resp got lat=%0d err=%b exp 1 0", lat, cur_err); end
    ack();
    send(1'b0, 1'b0, 32'd124, 32'd0, 4'h0, 1'b0, lat, rh);
    checks++; if (cur_rdata !== 32'h1234CCDD) begin failures++;
      $display("FAIL store_readback got=%h exp=1234ccdd", cur_rdata); end
    ack();
  endtask

  task automatic test_wait_states();
    int lat, rh;
    u3.mem[5] = 32'hA5A55A5A;
    send(1'b1, 1'b0, 32'd20, 32'd0, 4'h0, 1'b0, lat, rh);
    checks++; if (lat !== 4) begin failures++; $display("FAIL w3_latency got=%0d exp=4", lat); end
    checks++; if (rh !== 0) begin failures++; $display("FAIL w3_ready_busy got=%0d exp=0", rh); end
    checks++; if (cur_rdata !== 32'hA5A55A5A || cur_err !== 1'b0) begin failures++;
      $display("FAIL w3_load got=%h err=%b exp=a5a55a5a err=0", cur_rdata, cur_err); end
    ack();
    checks++; if (cur_ready !== 1'b1) begin failures++; $display("FAIL w3_ready_after got=%b exp=1", cur_ready); end
  endtask

  task automatic test_backpressure();
    int lat, rh, bad;
    send(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1, lat, rh);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (cur_rdata !== 32'hDEADBEEF || cur_err !== 1'b0 || cur_valid !== 1'b1 || cur_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d bad_cycles exp=0", bad); end
    ack();
    checks++; if (cur_ready !== 1'b1 || cur_valid !== 1'b0 || cur_rdata !== 32'd0) begin failures++;
      $display("FAIL bp_release got ready=%b valid=%b rdata=%h exp 1 0 0", cur_ready, cur_valid, cur_rdata); end
    req_valid = 1'b0;
  endtask

  task automatic test_errors();
    int lat, rh;
    u0.mem[1] = 32'h11223344;
    send(1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 1'b0, lat, rh);
    checks++; if (cur_err !== 1'b1 || cur_rdata !== 32'd0) begin failures++;
      $display("FAIL err_misaligned_store got err=%b rdata=%h exp 1 0", cur_err, cur_rdata); end
    ack();
    checks++; if (u0.mem[1] !== 32'h11223344) begin failures++;
      $display("FAIL err_store_nowrite got=%h exp=11223344", u0.mem[1]); end
    send(1'b0, 1'b0, 32'd128, 32'd0, 4'h0, 1'b0, lat, rh);
    checks++; if (cur_err !== 1'b1 || cur_rdata !== 32'd0) begin failures++;
      $display("FAIL err_range_load got err=%b rdata=%h exp 1 0", cur_err, cur_rdata); end
    ack();
    checks++; if (cur_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", cur_err); end
    send(1'b0, 1'b0, 32'd4, 32'd0, 4'h0, 1'b0, lat, rh);
    checks++; if (cur_err !== 1'b0 || cur_rdata !== 32'h11223344) begin failures++;
      $display("FAIL err_last_valid got err=%b rdata=%h exp 0 11223344", cur_err, cur_rdata); end
    ack();
  endtask

  task automatic test_reset_in_wait();
    int lat, rh;
    u3.mem[2] = 32'hCAFEF00D;
    @(negedge clk);
    sel = 1'b1; req_we = 1'b1; req_addr = 32'd8; req_wdata = 32'h0; req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (b_resp_valid !== 1'b0 || b_dbg !== 2'd0 || b_req_ready !== 1'b1) begin failures++;
      $display("FAIL rst_wait_state got valid=%b state=%0d ready=%b exp 0 0 1", b_resp_valid, b_dbg, b_req_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (u3.mem[2] !== 32'hCAFEF00D) begin failures++;
      $display("FAIL rst_store_dropped got=%h exp=cafef00d", u3.mem[2]); end
    checks++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin failures++;
      $display("FAIL rst_ready_after got ready=%b valid=%b exp 1 0", b_req_ready, b_resp_valid); end
    send(1'b1, 1'b0, 32'd8, 32'd0, 4'h0, 1'b0, lat, rh);
    checks++; if (lat !== 4 || cur_rdata !== 32'hCAFEF00D) begin failures++;
      $display("FAIL rst_readback got lat=%0d rdata=%h exp 4 cafef00d", lat, cur_rdata); end
    ack();
  endtask

  initial begin
    checks = 0; failures = 0;
    sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
    test_reset();
    test_load_w0();
    test_store_strobe();
    test_wait_states();
    test_backpressure();
    test_errors();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
